liberar_maquina_credito: RTL and testbench

Sequential payment controller for the car-wash machine. It replaces the single-cycle note/wash-type match with a credit accumulator. The customer selects a wash type, then inserts notes one at a time. The block releases the machine once accumulated credit reaches the price of the selected wash, pays out change, and refunds the full credit on cancel or timeout. It sits between the note reader and the wash-machine enable.

---
 rtl/liberar_maquina_pkg.sv | 26 ++
 rtl/temporizador_inatividade.sv | 40 ++++
 rtl/liberar_maquina_credito.sv | 154 +++++++++++++++
 tb/tb_liberar_maquina_credito.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/liberar_maquina_pkg.sv
// Shared types and helpers for the car-wash payment controller.
//   estado_t   : controller states (idle, wash selected, machine released)
//   nota_valor : maps the 2-bit note code from the reader to its currency value
package liberar_maquina_pkg;

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        SELECIONADO = 2'd1,
        LIBERADO    = 2'd2
    } estado_t;

    localparam int NOTA_VALOR_W = 5;

    // Note codes 0..3 correspond to notes of 2, 5, 10 and 20 units.
    function automatic logic [NOTA_VALOR_W-1:0] nota_valor(input logic [1:0] cod);
        logic [NOTA_VALOR_W-1:0] valor;
        case (cod)
            2'd0:    valor = 5'd2;
            2'd1:    valor = 5'd5;
            2'd2:    valor = 5'd10;
            default: valor = 5'd20;
        endcase
        return valor;
    endfunction

endpackage

// File: rtl/temporizador_inatividade.sv
// Inactivity timer for the payment controller.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   carregar   : restart the countdown (selection made or note inserted)
//   limpar     : stop the timer (transaction ended); wins over carregar
//   expirou    : high during the last idle cycle, so the controller's registered
//                refund lands exactly TIMEOUT cycles after the last restart
module temporizador_inatividade #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic carregar,
    input  logic limpar,
    output logic expirou
);

    // Holds values up to TIMEOUT-1; a count of zero means the timer is stopped.
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CARGA = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] contagem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contagem <= '0;
        end else if (limpar) begin
            contagem <= '0;
        end else if (carregar) begin
            contagem <= CARGA;
        end else if (contagem != '0) begin
            contagem <= contagem - 1'b1;
        end
    end

    // Count one is reached TIMEOUT-1 cycles after loading; the controller
    // registers its refund on the following edge.
    assign expirou = (contagem == CNT_W'(1));

endmodule

// File: rtl/liberar_maquina_credito.sv
// Credit-accumulating payment controller for the car-wash machine.
// Ports:
//   clk, rst_n     : clock and asynchronous active-low reset
//   preco_tab      : flat price table, type i at [i*CRED_W +: CRED_W]
//   sel_valida     : wash type selection pulse, with sel_lavagem
//   nota_valida    : note inserted pulse, with nota_cod
//   cancelar       : customer cancel pulse
//   lavagem_fim    : wash complete pulse from the machine
//   liberar        : machine enable level
//   credito        : accumulated credit
//   troco          : change/refund value, qualified by troco_valido
//   troco_valido   : one pulse per transaction end
//   nota_rejeitada : note refused pulse
//   ocupado        : high whenever not idle
module liberar_maquina_credito
    import liberar_maquina_pkg::*;
#(
    parameter int N_LAVAGENS = 4,
    parameter int CRED_W     = 8,
    parameter int TIMEOUT    = 1000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_LAVAGENS*CRED_W-1:0] preco_tab,
    input  logic                         sel_valida,
    input  logic [$clog2(N_LAVAGENS)-1:0] sel_lavagem,
    input  logic                         nota_valida,
    input  logic [1:0]                   nota_cod,
    input  logic                         cancelar,
    input  logic                         lavagem_fim,
    output logic                         liberar,
    output logic [CRED_W-1:0]            credito,
    output logic [CRED_W-1:0]            troco,
    output logic                         troco_valido,
    output logic                         nota_rejeitada,
    output logic                         ocupado
);

    estado_t           estado, estado_prox;
    logic [CRED_W-1:0] preco, preco_prox;
    logic [CRED_W-1:0] credito_prox, troco_prox;
    logic              troco_valido_prox, rejeita_prox;
    logic              carregar, limpar, expirou;
    logic [CRED_W:0]   soma;
    logic              estouro;
    logic [CRED_W-1:0] cred_atual;

    temporizador_inatividade #(
        .TIMEOUT (TIMEOUT)
    ) u_temporizador (
        .clk      (clk),
        .rst_n    (rst_n),
        .carregar (carregar),
        .limpar   (limpar),
        .expirou  (expirou)
    );

    // One extra bit on the sum exposes a note that would overflow the credit.
    assign soma    = {1'b0, credito} + (CRED_W+1)'(nota_valor(nota_cod));
    assign estouro = soma[CRED_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado         <= OCIOSO;
            preco          <= '0;
            credito        <= '0;
            troco          <= '0;
            troco_valido   <= 1'b0;
            nota_rejeitada <= 1'b0;
        end else begin
            estado         <= estado_prox;
            preco          <= preco_prox;
            credito        <= credito_prox;
            troco          <= troco_prox;
            troco_valido   <= troco_valido_prox;
            nota_rejeitada <= rejeita_prox;
        end
    end

    always_comb begin
        estado_prox       = estado;
        preco_prox        = preco;
        credito_prox      = credito;
        troco_prox        = troco;
        troco_valido_prox = 1'b0;
        rejeita_prox      = 1'b0;
        carregar          = 1'b0;
        limpar            = 1'b0;
        cred_atual        = credito;

        case (estado)
            OCIOSO: begin
                if (nota_valida) begin
                    rejeita_prox = 1'b1;
                end
                if (sel_valida && (int'(sel_lavagem) < N_LAVAGENS)) begin
                    preco_prox   = preco_tab[sel_lavagem*CRED_W +: CRED_W];
                    credito_prox = '0;
                    carregar     = 1'b1;
                    estado_prox  = SELECIONADO;
                end
            end

            SELECIONADO: begin
                // Any note, accepted or refused, restarts the inactivity timer.
                if (nota_valida) begin
                    carregar = 1'b1;
                    if (estouro) begin
                        rejeita_prox = 1'b1;
                    end else begin
                        cred_atual = soma[CRED_W-1:0];
                    end
                end

                // Cancel takes priority over release, and refunds the credit
                // including a note accepted in the same cycle. A note in the
                // expiry cycle means the customer was not idle.
                if (cancelar || (expirou && !nota_valida)) begin
                    troco_prox        = cred_atual;
                    troco_valido_prox = 1'b1;
                    credito_prox      = '0;
                    limpar            = 1'b1;
                    estado_prox       = OCIOSO;
                end else if (nota_valida && !estouro && (cred_atual >= preco)) begin
                    troco_prox        = cred_atual - preco;
                    troco_valido_prox = 1'b1;
                    credito_prox      = '0;
                    limpar            = 1'b1;
                    estado_prox       = LIBERADO;
                end else begin
                    credito_prox = cred_atual;
                end
            end

            LIBERADO: begin
                if (nota_valida) begin
                    rejeita_prox = 1'b1;
                end
                if (lavagem_fim) begin
                    estado_prox = OCIOSO;
                end
            end

            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    // Decoded straight from the state register, so reset drops them at once.
    assign liberar = (estado == LIBERADO);
    assign ocupado = (estado != OCIOSO);

endmodule

// File: tb/tb_liberar_maquina_credito.sv
// Self-checking bench for liberar_maquina_credito. Two instances: dut_a with
// default parameters (prices 10/15/20/30) and dut_b with CRED_W=5, TIMEOUT=8
// (prices 30/0/3/3). Expected refund/change and rejection events are queued by
// the stimulus and checked by per-instance monitors, including their cycle.
module tb_liberar_maquina_credito;

    typedef struct {
        int troco;
        int lib;
        int cyc;
    } troco_exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    troco_exp_t qta[$];
    troco_exp_t qtb[$];
    int         qra[$];
    int         qrb[$];
    troco_exp_t ea, eb;
    int         ra, rb;

    // Instance A signals
    logic        rst_n_a;
    logic        a_sel, a_nota, a_canc, a_fim;
    logic [1:0]  a_lav, a_cod;
    logic        a_liberar, a_troco_valido, a_rej, a_ocupado;
    logic [7:0]  a_credito, a_troco;
    logic [31:0] a_tab = {8'd30, 8'd20, 8'd15, 8'd10};

    // Instance B signals
    logic        rst_n_b;
    logic        b_sel, b_nota, b_canc, b_fim;
    logic [1:0]  b_lav, b_cod;
    logic        b_liberar, b_troco_valido, b_rej, b_ocupado;
    logic [4:0]  b_credito, b_troco;
    logic [19:0] b_tab = {5'd3, 5'd3, 5'd0, 5'd30};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    liberar_maquina_credito dut_a (
        .clk            (clk),
        .rst_n          (rst_n_a),
        .preco_tab      (a_tab),
        .sel_valida     (a_sel),
        .sel_lavagem    (a_lav),
        .nota_valida    (a_nota),
        .nota_cod       (a_cod),
        .cancelar       (a_canc),
        .lavagem_fim    (a_fim),
        .liberar        (a_liberar),
        .credito        (a_credito),
        .troco          (a_troco),
        .troco_valido   (a_troco_valido),
        .nota_rejeitada (a_rej),
        .ocupado        (a_ocupado)
    );

    liberar_maquina_credito #(
        .N_LAVAGENS (4),
        .CRED_W     (5),
        .TIMEOUT    (8)
    ) dut_b (
        .clk            (clk),
        .rst_n          (rst_n_b),
        .preco_tab      (b_tab),
        .sel_valida     (b_sel),
        .sel_lavagem    (b_lav),
        .nota_valida    (b_nota),
        .nota_cod       (b_cod),
        .cancelar       (b_canc),
        .lavagem_fim    (b_fim),
        .liberar        (b_liberar),
        .credito        (b_credito),
        .troco          (b_troco),
        .troco_valido   (b_troco_valido),
        .nota_rejeitada (b_rej),
        .ocupado        (b_ocupado)
    );

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic unexpectedEvent(input string name, input int actual);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=%0d required=no event (cycle %0d)", name, actual, cyc);
    endtask

    // Drives one cycle of pulses on the chosen instance; called at a negedge
    // and returns at the next negedge, when the registered response is visible.
    task automatic applyStimulus(input bit to_b, input bit sel, input logic [1:0] lav,
                                 input bit nota, input logic [1:0] cod,
                                 input bit canc, input bit fim);
        if (!to_b) begin
            a_sel = sel; a_lav = lav; a_nota = nota; a_cod = cod; a_canc = canc; a_fim = fim;
        end else begin
            b_sel = sel; b_lav = lav; b_nota = nota; b_cod = cod; b_canc = canc; b_fim = fim;
        end
        @(negedge clk);
        a_sel = 0; a_nota = 0; a_canc = 0; a_fim = 0;
        b_sel = 0; b_nota = 0; b_canc = 0; b_fim = 0;
    endtask

    task automatic expectTroco(input bit to_b, input int troco, input int lib, input int at_cyc);
        troco_exp_t e;
        e.troco = troco; e.lib = lib; e.cyc = at_cyc;
        if (!to_b) qta.push_back(e); else qtb.push_back(e);
    endtask

    task automatic expectReject(input bit to_b, input int at_cyc);
        if (!to_b) qra.push_back(at_cyc); else qrb.push_back(at_cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor for instance A
    always @(negedge clk) begin
        if (a_troco_valido) begin
            if (qta.size() == 0) begin
                unexpectedEvent("troco_a_pulse", int'(a_troco));
            end else begin
                ea = qta.pop_front();
                checkOutput("troco_a_value", int'(a_troco), ea.troco);
                checkOutput("troco_a_liberar", int'(a_liberar), ea.lib);
                checkOutput("troco_a_cycle", cyc, ea.cyc);
            end
        end
        if (a_rej) begin
            if (qra.size() == 0) begin
                unexpectedEvent("reject_a_pulse", int'(a_credito));
            end else begin
                ra = qra.pop_front();
                checkOutput("reject_a_cycle", cyc, ra);
            end
        end
    end

    // Monitor for instance B
    always @(negedge clk) begin
        if (b_troco_valido) begin
            if (qtb.size() == 0) begin
                unexpectedEvent("troco_b_pulse", int'(b_troco));
            end else begin
                eb = qtb.pop_front();
                checkOutput("troco_b_value", int'(b_troco), eb.troco);
                checkOutput("troco_b_liberar", int'(b_liberar), eb.lib);
                checkOutput("troco_b_cycle", cyc, eb.cyc);
            end
        end
        if (b_rej) begin
            if (qrb.size() == 0) begin
                unexpectedEvent("reject_b_pulse", int'(b_credito));
            end else begin
                rb = qrb.pop_front();
                checkOutput("reject_b_cycle", cyc, rb);
            end
        end
    end

    initial begin
        int c0;
        a_sel = 0; a_lav = 0; a_nota = 0; a_cod = 0; a_canc = 0; a_fim = 0;
        b_sel = 0; b_lav = 0; b_nota = 0; b_cod = 0; b_canc = 0; b_fim = 0;
        rst_n_a = 0; rst_n_b = 0;
        idle(3);
        checkOutput("reset_liberar", int'(a_liberar), 0);
        checkOutput("reset_credito", int'(a_credito), 0);
        checkOutput("reset_troco", int'(a_troco), 0);
        checkOutput("reset_troco_valido", int'(a_troco_valido), 0);
        checkOutput("reset_rejeitada", int'(a_rej), 0);
        checkOutput("reset_ocupado", int'(a_ocupado), 0);
        rst_n_a = 1; rst_n_b = 1;
        idle(2);

        // Type 1 (15): 10 + 10 releases with change 5
        $display("[TB] purchase with change");
        applyStimulus(0, 1, 2'd1, 0, 2'd0, 0, 0);
        checkOutput("sel_ocupado", int'(a_ocupado), 1);
        checkOutput("sel_credito", int'(a_credito), 0);
        applyStimulus(0, 0, 2'd0, 1, 2'd2, 0, 0);
        checkOutput("note10_credito", int'(a_credito), 10);
        checkOutput("note10_liberar", int'(a_liberar), 0);
        expectTroco(0, 5, 1, cyc + 1);
        applyStimulus(0, 0, 2'd0, 1, 2'd2, 0, 0);
        checkOutput("release_liberar", int'(a_liberar), 1);
        checkOutput("release_credito", int'(a_credito), 0);
        idle(2);
        checkOutput("release_hold_liberar", int'(a_liberar), 1);
        checkOutput("release_hold_troco", int'(a_troco), 5);
        expectReject(0, cyc + 1);
        applyStimulus(0, 0, 2'd0, 1, 2'd3, 0, 0);
        checkOutput("liberado_note_credito", int'(a_credito), 0);
        applyStimulus(0, 1, 2'd2, 0, 2'd0, 1, 0);
        checkOutput("liberado_cancel_liberar", int'(a_liberar), 1);
        applyStimulus(0, 0, 2'd0, 0, 2'd0, 0, 1);
        checkOutput("fim_liberar", int'(a_liberar), 0);
        checkOutput("fim_ocupado", int'(a_ocupado), 0);

        // Note while idle is refused
        expectReject(0, cyc + 1);
        applyStimulus(0, 0, 2'd0, 1, 2'd2, 0, 0);
        checkOutput("idle_note_credito", int'(a_credito), 0);
        checkOutput("idle_note_ocupado", int'(a_ocupado), 0);

        // Type 3 (30): 20 + 5, second selection ignored, 2 more, cancel -> 27
        $display("[TB] cancel with price lock");
        applyStimulus(0, 1, 2'd3, 0, 2'd0, 0, 0);
        applyStimulus(0, 0, 2'd0, 1, 2'd3, 0, 0);
        applyStimulus(0, 0, 2'd0, 1, 2'd1, 0, 0);
        checkOutput("cancel_credito25", int'(a_credito), 25);
        applyStimulus(0, 1, 2'd0, 0, 2'd0, 0, 0);
        applyStimulus(0, 0, 2'd0, 1, 2'd0, 0, 0);
        checkOutput("locked_price_liberar", int'(a_liberar), 0);
        checkOutput("locked_price_credito", int'(a_credito), 27);
        expectTroco(0, 27, 0, cyc + 1);
        applyStimulus(0, 0, 2'd0, 0, 2'd0, 1, 0);
        checkOutput("cancel_ocupado", int'(a_ocupado), 0);
        checkOutput("cancel_liberar", int'(a_liberar), 0);
        checkOutput("cancel_credito", int'(a_credito), 0);

        // Type 2 (20): one note of 5, then timeout refund exactly 1000 cycles later
        $display("[TB] timeout refund");
        applyStimulus(0, 1, 2'd2, 0, 2'd0, 0, 0);
        idle(3);
        c0 = cyc;
        expectTroco(0, 5, 0, c0 + 1000);
        applyStimulus(0, 0, 2'd0, 1, 2'd1, 0, 0);
        checkOutput("timeout_credito", int'(a_credito), 5);
        idle(998);
        checkOutput("timeout_before_ocupado", int'(a_ocupado), 1);
        idle(1);
        checkOutput("timeout_after_ocupado", int'(a_ocupado), 0);
        checkOutput("timeout_troco", int'(a_troco), 5);

        // Simultaneous note 10 and cancel with credit 5, price 20 -> refund 15
        $display("[TB] note with cancel");
        applyStimulus(0, 1, 2'd2, 0, 2'd0, 0, 0);
        applyStimulus(0, 0, 2'd0, 1, 2'd1, 0, 0);
        expectTroco(0, 15, 0, cyc + 1);
        applyStimulus(0, 0, 2'd0, 1, 2'd2, 1, 0);
        checkOutput("notecancel_liberar", int'(a_liberar), 0);
        checkOutput("notecancel_ocupado", int'(a_ocupado), 0);
        checkOutput("notecancel_credito", int'(a_credito), 0);

        // Instance B: price 30 in 5 bits; 20+5+2+2=29, 20 refused, 2 -> 31, change 1
        $display("[TB] overflow boundary");
        applyStimulus(1, 1, 2'd0, 0, 2'd0, 0, 0);
        applyStimulus(1, 0, 2'd0, 1, 2'd3, 0, 0);
        applyStimulus(1, 0, 2'd0, 1, 2'd1, 0, 0);
        applyStimulus(1, 0, 2'd0, 1, 2'd0, 0, 0);
        applyStimulus(1, 0, 2'd0, 1, 2'd0, 0, 0);
        checkOutput("b_credito29", int'(b_credito), 29);
        expectReject(1, cyc + 1);
        applyStimulus(1, 0, 2'd0, 1, 2'd3, 0, 0);
        checkOutput("b_overflow_credito", int'(b_credito), 29);
        checkOutput("b_overflow_liberar", int'(b_liberar), 0);
        expectTroco(1, 1, 1, cyc + 1);
        applyStimulus(1, 0, 2'd0, 1, 2'd0, 0, 0);
        checkOutput("b_max_liberar", int'(b_liberar), 1);
        checkOutput("b_max_credito", int'(b_credito), 0);
        applyStimulus(1, 0, 2'd0, 0, 2'd0, 0, 1);
        checkOutput("b_fim_liberar", int'(b_liberar), 0);

        // Instance B: price 0, the first note releases with its full value as change
        $display("[TB] zero price");
        applyStimulus(1, 1, 2'd1, 0, 2'd0, 0, 0);
        checkOutput("b_zero_liberar_before", int'(b_liberar), 0);
        expectTroco(1, 5, 1, cyc + 1);
        applyStimulus(1, 0, 2'd0, 1, 2'd1, 0, 0);
        checkOutput("b_zero_liberar", int'(b_liberar), 1);
        applyStimulus(1, 0, 2'd0, 0, 2'd0, 0, 1);
        checkOutput("b_zero_fim_ocupado", int'(b_ocupado), 0);

        // Asynchronous reset while released, then while holding credit
        $display("[TB] async reset");
        applyStimulus(0, 1, 2'd0, 0, 2'd0, 0, 0);
        expectTroco(0, 0, 1, cyc + 1);
        applyStimulus(0, 0, 2'd0, 1, 2'd2, 0, 0);
        checkOutput("prereset_liberar", int'(a_liberar), 1);
        #2 rst_n_a = 0;
        #1;
        checkOutput("areset_liberar", int'(a_liberar), 0);
        checkOutput("areset_ocupado", int'(a_ocupado), 0);
        checkOutput("areset_credito", int'(a_credito), 0);
        idle(2);
        rst_n_a = 1;
        idle(1);
        applyStimulus(0, 1, 2'd3, 0, 2'd0, 0, 0);
        applyStimulus(0, 0, 2'd0, 1, 2'd2, 0, 0);
        checkOutput("prereset2_credito", int'(a_credito), 10);
        #2 rst_n_a = 0;
        #1;
        checkOutput("areset2_credito", int'(a_credito), 0);
        checkOutput("areset2_ocupado", int'(a_ocupado), 0);
        idle(2);
        rst_n_a = 1;

        idle(12);
        checkOutput("queue_troco_a_empty", qta.size(), 0);
        checkOutput("queue_troco_b_empty", qtb.size(), 0);
        checkOutput("queue_reject_a_empty", qra.size(), 0);
        checkOutput("queue_reject_b_empty", qrb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
